// File: rtl/bd_wrapper_pkg.sv
// Shared definitions for the AXI4-Stream example design core:
// response codes, register map offsets and the stream generator state type.
package bd_wrapper_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    INIT_COUNTER,
    SEND_STREAM,
    DONE
  } streamState_t;

  // Word index within the bank; byte addresses above 0xC alias onto it.
  function automatic logic [1:0] regIndex(input logic [3:0] byteAddr);
    return byteAddr[3:2];
  endfunction

endpackage

// File: rtl/bd_wrapper_axil_reg_bank.sv
// AXI4-Lite slave with four 32-bit byte-writable registers.
// Write and read channels operate independently; every response is OKAY.
module axil_reg_bank
  import bd_wrapper_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] wrMask;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdMux;
  logic                          awReady;
  logic                          wReady;
  logic                          bValid;
  logic                          arReady;
  logic                          rValid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rData;
  logic                          wrFire;
  logic                          rdFire;
  logic [1:0]                    wrIdx;

  for (genvar b = 0; b < STRB_W; b++) begin : gLane
    assign wrMask[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
  end

  assign wrFire = awReady && wReady && S_AXI_AWVALID && S_AXI_WVALID;
  assign rdFire = arReady && S_AXI_ARVALID;
  assign wrIdx  = regIndex(S_AXI_AWADDR[3:0]);

  always_comb begin
    rdMux = '0;
    case ({regIndex(S_AXI_ARADDR[3:0]), 2'b00})
      REG0_OFFSET: rdMux = regs[0];
      REG1_OFFSET: rdMux = regs[1];
      REG2_OFFSET: rdMux = regs[2];
      REG3_OFFSET: rdMux = regs[3];
      default:     rdMux = '0;
    endcase
  end

  // Ready pulses are one cycle wide: the "!awReady" term drops them on the handshake edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awReady <= 1'b0;
      wReady  <= 1'b0;
      bValid  <= 1'b0;
      regs    <= '{default: '0};
    end else begin
      awReady <= !awReady && S_AXI_AWVALID && S_AXI_WVALID && !bValid;
      wReady  <= !awReady && S_AXI_AWVALID && S_AXI_WVALID && !bValid;
      if (wrFire) begin
        regs[wrIdx] <= (regs[wrIdx] & ~wrMask) | (S_AXI_WDATA & wrMask);
        bValid      <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arReady <= 1'b0;
      rValid  <= 1'b0;
      rData   <= '0;
    end else begin
      arReady <= !arReady && S_AXI_ARVALID && !rValid;
      if (rdFire) begin
        rValid <= 1'b1;
        rData  <= rdMux;
      end else if (S_AXI_RREADY) begin
        rValid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awReady;
  assign S_AXI_WREADY  = wReady;
  assign S_AXI_BVALID  = bValid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arReady;
  assign S_AXI_RVALID  = rValid;
  assign S_AXI_RDATA   = rData;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: rtl/bd_wrapper.sv
// User processing core: AXI4-Lite register bank plus an AXI4-Stream master that
// emits one fixed 8-word packet (0x1..0x8) a fixed delay after reset release.
module bd_wrapper
  import bd_wrapper_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH   = 4,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_START_COUNT      = 32,
  parameter int unsigned C_NUM_WORDS          = 8
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0]   S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int unsigned CNT_W  = $clog2(C_M_START_COUNT + 1);
  localparam int unsigned WORD_W = $clog2(C_NUM_WORDS);

  streamState_t      state;
  streamState_t      stateNext;
  logic [CNT_W-1:0]  startCnt;
  logic [CNT_W-1:0]  startCntNext;
  logic [WORD_W-1:0] wordIdx;
  logic [WORD_W-1:0] wordIdxNext;
  logic              lastWord;
  logic              unusedProt;

  assign unusedProt = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  axil_reg_bank #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH)
  ) uRegBank (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  assign lastWord = (wordIdx == WORD_W'(C_NUM_WORDS - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      startCnt <= '0;
      wordIdx  <= '0;
    end else begin
      state    <= stateNext;
      startCnt <= startCntNext;
      wordIdx  <= wordIdxNext;
    end
  end

  always_comb begin
    stateNext    = state;
    startCntNext = startCnt;
    wordIdxNext  = wordIdx;
    case (state)
      IDLE: begin
        startCntNext = '0;
        wordIdxNext  = '0;
        stateNext    = INIT_COUNTER;
      end
      INIT_COUNTER: begin
        if (startCnt == CNT_W'(C_M_START_COUNT - 1)) begin
          startCntNext = '0;
          stateNext    = SEND_STREAM;
        end else begin
          startCntNext = startCnt + CNT_W'(1);
        end
      end
      SEND_STREAM: begin
        if (M_AXIS_TREADY) begin
          if (lastWord) begin
            stateNext = DONE;
          end else begin
            wordIdxNext = wordIdx + WORD_W'(1);
          end
        end
      end
      DONE:    stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  assign M_AXIS_TVALID = (state == SEND_STREAM);
  assign M_AXIS_TLAST  = (state == SEND_STREAM) && lastWord;
  assign M_AXIS_TDATA  = C_M_AXIS_TDATA_WIDTH'(wordIdx) + C_M_AXIS_TDATA_WIDTH'(1);
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_bd_wrapper.sv
// Scoreboard bench for bd_wrapper: lite register accesses and the post-reset stream packet.
module tb_bd_wrapper;

  logic        tb_ACLK;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  int checks   = 0;
  int failures = 0;

  logic [31:0] streamQ [$];
  logic        lastQ   [$];
  logic [31:0] litQ    [$];

  bd_wrapper #(
    .C_S_AXI_DATA_WIDTH   (32),
    .C_S_AXI_ADDR_WIDTH   (4),
    .C_M_AXIS_TDATA_WIDTH (32),
    .C_M_START_COUNT      (32),
    .C_NUM_WORDS          (8)
  ) dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Holds reset a few cycles, then loads the expected packet before release.
  task automatic doReset();
    ARESETN       = 1'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    streamQ.delete();
    lastQ.delete();
    for (int i = 1; i <= 8; i++) begin
      streamQ.push_back(32'(i));
      lastQ.push_back(i == 8);
    end
    ARESETN = 1'b1;
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bHold, output logic [1:0] resp, output logic held, output logic ok);
    ok   = 1'b0;
    held = 1'b1;
    resp = 2'bxx;
    @(negedge tb_ACLK);
    S_AXI_AWADDR  = addr;
    S_AXI_AWPROT  = 3'b010;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_ACLK);
      if (S_AXI_AWREADY === 1'b1 && S_AXI_WREADY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge tb_ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge tb_ACLK);
        if (S_AXI_BVALID === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      for (int i = 0; i < bHold; i++) begin
        @(negedge tb_ACLK);
        if (S_AXI_BVALID !== 1'b1) held = 1'b0;
      end
      resp         = S_AXI_BRESP;
      S_AXI_BREADY = 1'b1;
      @(posedge tb_ACLK);
      #1;
      S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic ok);
    ok   = 1'b0;
    data = 'x;
    resp = 2'bxx;
    @(negedge tb_ACLK);
    S_AXI_ARADDR  = addr;
    S_AXI_ARPROT  = 3'b001;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_ACLK);
      if (S_AXI_ARREADY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge tb_ACLK);
    #1;
    S_AXI_ARVALID = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge tb_ACLK);
        if (S_AXI_RVALID === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      data         = S_AXI_RDATA;
      resp         = S_AXI_RRESP;
      S_AXI_RREADY = 1'b1;
      @(posedge tb_ACLK);
      #1;
      S_AXI_RREADY = 1'b0;
    end
  endtask

  // Drives TREADY and pops the scoreboard on every beat the DUT hands over.
  task automatic runStream(input bit randomReady, input int stopAfter, output int beats);
    int          cycles;
    logic [31:0] prevData;
    bit          prevStall;
    logic [31:0] expData;
    logic        expLast;
    cycles    = 0;
    beats     = 0;
    prevStall = 1'b0;
    prevData  = '0;
    while (beats < stopAfter && cycles < 2000) begin
      @(negedge tb_ACLK);
      cycles++;
      if (prevStall) begin
        checks++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prevData) begin
          failures++;
          $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h",
                   M_AXIS_TVALID, M_AXIS_TDATA, prevData);
        end
      end
      M_AXIS_TREADY = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      prevStall     = 1'b0;
      if (M_AXIS_TVALID === 1'b1) begin
        if (M_AXIS_TREADY) begin
          checks++;
          if (streamQ.size() == 0) begin
            failures++;
            $display("FAIL extra_beat got data=%h exp no beat", M_AXIS_TDATA);
          end else begin
            expData = streamQ.pop_front();
            expLast = lastQ.pop_front();
            if (M_AXIS_TDATA !== expData || M_AXIS_TLAST !== expLast || M_AXIS_TSTRB !== 4'hF) begin
              failures++;
              $display("FAIL beat got data=%h last=%b strb=%h exp data=%h last=%b strb=f",
                       M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TSTRB, expData, expLast);
            end
          end
          beats++;
        end else begin
          prevStall = 1'b1;
          prevData  = M_AXIS_TDATA;
        end
      end
    end
    checks++;
    if (beats < stopAfter) begin
      failures++;
      $display("FAIL stream_timeout got beats=%0d exp beats=%0d", beats, stopAfter);
    end
    @(posedge tb_ACLK);
    #1;
    M_AXIS_TREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        ok;
    ARESETN = 1'b0;
    #3;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      failures++;
      $display("FAIL reset_lite_flags got=%b exp=00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
    end
    checks++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST} !== 2'b00) begin
      failures++;
      $display("FAIL reset_stream got valid=%b last=%b exp 0 0", M_AXIS_TVALID, M_AXIS_TLAST);
    end
    checks++;
    if (S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00) begin
      failures++;
      $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b exp 0 00 00",
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP);
    end
    doReset();
    litQ.push_back(32'h0);
    axiRead(4'h8, rd, rr, ok);
    checks++;
    if (!ok || rd !== litQ.pop_front()) begin
      failures++;
      $display("FAIL reset_reg2 got ok=%b data=%h exp 00000000", ok, rd);
    end
  endtask

  task automatic test_lite_basic();
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    logic        held;
    logic        ok;
    axiWrite(4'h0, 32'h0101FFFF, 4'hF, 3, br, held, ok);
    checks++;
    if (!ok || br !== 2'b00) begin
      failures++;
      $display("FAIL write0_bresp got ok=%b bresp=%b exp 1 00", ok, br);
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL bvalid_hold got held=%b exp 1", held);
    end
    litQ.push_back(32'h0101FFFF);
    axiRead(4'h0, rd, rr, ok);
    checks++;
    if (!ok || rd !== litQ.pop_front() || rr !== 2'b00) begin
      failures++;
      $display("FAIL read0 got ok=%b data=%h rresp=%b exp 1 0101ffff 00", ok, rd, rr);
    end
  endtask

  task automatic test_lite_regs();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [1:0]  rr;
    logic [1:0]  br;
    logic        held;
    logic        ok;
    logic [3:0]  addrs [4];
    logic [31:0] vals  [4];
    addrs = '{4'h4, 4'h8, 4'hC, 4'h0};
    vals  = '{32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011, 32'h0101FFFF};
    for (int i = 0; i < 3; i++) begin
      axiWrite(addrs[i], vals[i], 4'hF, 0, br, held, ok);
      checks++;
      if (!ok || br !== 2'b00) begin
        failures++;
        $display("FAIL write_reg%0d_bresp got ok=%b bresp=%b exp 1 00", i + 1, ok, br);
      end
    end
    for (int i = 0; i < 4; i++) begin
      litQ.push_back(vals[i]);
      axiRead(addrs[i], rd, rr, ok);
      exp = litQ.pop_front();
      checks++;
      if (!ok || rd !== exp || rr !== 2'b00) begin
        failures++;
        $display("FAIL read_addr%h got ok=%b data=%h rresp=%b exp 1 %h 00", addrs[i], ok, rd, rr, exp);
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    logic        held;
    logic        ok;
    axiWrite(4'h0, 32'hFFFFFFFF, 4'hF, 0, br, held, ok);
    axiWrite(4'h0, 32'h00000000, 4'b0010, 0, br, held, ok);
    litQ.push_back(32'hFFFF00FF);
    axiRead(4'h0, rd, rr, ok);
    checks++;
    if (!ok || rd !== litQ.pop_front()) begin
      failures++;
      $display("FAIL strobe got ok=%b data=%h exp ffff00ff", ok, rd);
    end
  endtask

  task automatic checkDone();
    repeat (4) @(negedge tb_ACLK);
    M_AXIS_TREADY = 1'b1;
    repeat (4) @(negedge tb_ACLK);
    checks++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0) begin
      failures++;
      $display("FAIL done_idle got valid=%b last=%b exp 0 0", M_AXIS_TVALID, M_AXIS_TLAST);
    end
    checks++;
    if (streamQ.size() != 0) begin
      failures++;
      $display("FAIL packet_len got remaining=%0d exp 0", streamQ.size());
    end
    M_AXIS_TREADY = 1'b0;
  endtask

  task automatic test_stream_full();
    int beats;
    doReset();
    runStream(1'b0, 8, beats);
    checkDone();
  endtask

  task automatic test_back_to_back_backpressure();
    int beats;
    doReset();
    runStream(1'b1, 8, beats);
    checkDone();
  endtask

  task automatic test_reset_mid_packet();
    int          beats;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    logic        held;
    logic        ok;
    doReset();
    axiWrite(4'h4, 32'h12345678, 4'hF, 0, br, held, ok);
    runStream(1'b0, 3, beats);
    #1;
    ARESETN = 1'b0;
    #1;
    checks++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got valid=%b last=%b bvalid=%b exp 0 0 0",
               M_AXIS_TVALID, M_AXIS_TLAST, S_AXI_BVALID);
    end
    doReset();
    litQ.push_back(32'h0);
    axiRead(4'h4, rd, rr, ok);
    checks++;
    if (!ok || rd !== litQ.pop_front()) begin
      failures++;
      $display("FAIL midreset_reg1 got ok=%b data=%h exp 00000000", ok, rd);
    end
    runStream(1'b0, 8, beats);
    checkDone();
  endtask

  initial begin
    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    M_AXIS_TREADY = 1'b0;
    test_reset();
    test_lite_basic();
    test_lite_regs();
    test_strobe();
    test_stream_full();
    test_back_to_back_backpressure();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
